// File: rtl/count_uart_tx.sv
// Streams each new value of the 4-bit counter as an ASCII hex character over an 8N1 UART line.
// A single pending slot holds the most recent unsent value; overwriting it raises a sticky overrun flag.
module count_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] count,
  input  logic       tx_en,
  input  logic       ovr_clr,
  output logic       tx,
  output logic       busy,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        r_state;
  logic [3:0]    r_prevCount;
  logic [3:0]    r_pendingData;
  logic          r_pending;
  logic          r_overrun;
  logic          r_tx;
  logic          r_busy;
  logic [CW-1:0] r_baudCnt;
  logic [2:0]    r_bitIdx;
  logic [7:0]    r_shift;

  logic w_change;
  logic w_consume;
  logic w_bitDone;

  function automatic logic [7:0] hexAscii(input logic [3:0] v);
    if (v < 4'd10) return {4'h3, v};
    else           return 8'h37 + {4'h0, v};
  endfunction

  assign w_change  = (count != r_prevCount);
  assign w_consume = (r_state == IDLE) && r_pending && tx_en;
  assign w_bitDone = (r_baudCnt == BAUD_LAST);

  // A change landing on the same edge as a consume simply refills the slot; that is not an overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prevCount   <= 4'd0;
      r_pendingData <= 4'd0;
      r_pending     <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_change) begin
        r_prevCount   <= count;
        r_pendingData <= count;
        r_pending     <= 1'b1;
      end else if (w_consume) begin
        r_pending <= 1'b0;
      end

      if (w_change && r_pending && !w_consume) r_overrun <= 1'b1;
      else if (ovr_clr)                        r_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_baudCnt <= '0;
      r_bitIdx  <= 3'd0;
      r_shift   <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx      <= 1'b1;
          r_busy    <= 1'b0;
          r_baudCnt <= '0;
          r_bitIdx  <= 3'd0;
          if (w_consume) begin
            r_shift <= hexAscii(r_pendingData);
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= START;
          end
        end

        START: begin
          if (w_bitDone) begin
            r_baudCnt <= '0;
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_state   <= DATA;
          end else begin
            r_baudCnt <= r_baudCnt + CW'(1);
          end
        end

        // The shifter already dropped the bit on the line, so bit 0 is always the next one to send.
        DATA: begin
          if (w_bitDone) begin
            r_baudCnt <= '0;
            if (r_bitIdx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bitIdx <= r_bitIdx + 3'd1;
              r_tx     <= r_shift[0];
              r_shift  <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_baudCnt <= r_baudCnt + CW'(1);
          end
        end

        STOP: begin
          if (w_bitDone) begin
            r_baudCnt <= '0;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_baudCnt <= r_baudCnt + CW'(1);
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign tx      = r_tx;
  assign busy    = r_busy;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_count_uart_tx.sv
// Bench for count_uart_tx: a frame-timeline model checks tx/busy/overrun every cycle,
// directed scenarios pin decoded bytes and timing, then a randomized phase stresses the model.
module tb_count_uart_tx;

  localparam int CPB       = 4;
  localparam int FRAME_LEN = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] count = 4'd0;
  logic       tx_en = 1'b1;
  logic       ovr_clr = 1'b0;
  logic       tx;
  logic       busy;
  logic       overrun;

  logic checkEn = 1'b0;
  logic freeRun = 1'b0;
  int   nChecks = 0;
  int   nPass = 0;

  // Reference model state: pending slot plus the age of the frame in flight.
  logic [3:0] mPrev = 4'd0;
  logic [3:0] mData = 4'd0;
  logic       mPending = 1'b0;
  logic       mOverrun = 1'b0;
  logic       mInFrame = 1'b0;
  int         mAge = 0;
  logic [7:0] mByte = 8'd0;

  count_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .count   (count),
    .tx_en   (tx_en),
    .ovr_clr (ovr_clr),
    .tx      (tx),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] asciiOf(input logic [3:0] v);
    int n;
    n = v;
    if (n < 10) return 8'(48 + n);
    return 8'(65 + n - 10);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Advance the model one clock edge using the inputs as they stand just before the edge.
  always @(posedge clk) begin
    logic consume;
    logic change;
    if (!rst_n) begin
      mPrev = 4'd0; mData = 4'd0; mPending = 1'b0; mOverrun = 1'b0;
      mInFrame = 1'b0; mAge = 0; mByte = 8'd0;
    end else begin
      consume = !mInFrame && mPending && tx_en;
      change  = (count != mPrev);
      if (mInFrame) begin
        mAge++;
        if (mAge == FRAME_LEN) mInFrame = 1'b0;
      end
      if (consume) begin
        mInFrame = 1'b1;
        mAge     = 0;
        mByte    = asciiOf(mData);
      end
      if (change && mPending && !consume) mOverrun = 1'b1;
      else if (ovr_clr)                   mOverrun = 1'b0;
      if (change) begin
        mPending = 1'b1; mData = count; mPrev = count;
      end else if (consume) begin
        mPending = 1'b0;
      end
    end
  end

  // Every cycle: slot 0 is the start bit, slots 1..8 carry the byte LSB first, slot 9 is stop.
  always @(negedge clk) begin
    logic expTx;
    int   slot;
    if (checkEn) begin
      expTx = 1'b1;
      if (mInFrame) begin
        slot = mAge / CPB;
        if (slot == 0)      expTx = 1'b0;
        else if (slot <= 8) expTx = mByte[slot-1];
      end
      checkOutput("tx", {31'd0, tx}, {31'd0, expTx});
      checkOutput("busy", {31'd0, busy}, {31'd0, mInFrame});
      checkOutput("overrun", {31'd0, overrun}, {31'd0, mOverrun});
    end
  end

  always @(posedge clk) begin
    if (freeRun) begin
      #1;
      count = count + 4'd1;
    end
  end

  task automatic doReset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    count = 4'd0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic waitFall(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (!tx) return;
    end
    checkOutput("tx_fall_timeout", 32'd0, 32'd1);
  endtask

  // Entered on the negedge where tx first reads low; leaves on the first idle negedge after the frame.
  task automatic captureFrame(output logic [7:0] b, output int busyCycles);
    b = 8'd0;
    busyCycles = 0;
    for (int k = 0; k < 12 * CPB; k++) begin
      if (k > 0) @(negedge clk);
      if (busy) busyCycles++;
      for (int i = 0; i < 8; i++)
        if (k == CPB * (1 + i) + CPB / 2) b[i] = tx;
      if (k > 0 && !busy) break;
    end
  endtask

  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) count = 4'($urandom_range(15));
      tx_en   = ($urandom_range(9) != 0);
      ovr_clr = ($urandom_range(49) == 0);
      rst_n   = ($urandom_range(499) != 0);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    ovr_clr = 1'b0;
    tx_en   = 1'b1;
  endtask

  initial begin
    int         n;
    int         bc;
    logic [7:0] b;

    doReset(3);
    checkEn = 1'b1;
    repeat (50) @(negedge clk);
    checkOutput("t1_tx_idle", {31'd0, tx}, 32'd1);
    checkOutput("t1_busy_idle", {31'd0, busy}, 32'd0);
    checkOutput("t1_overrun_idle", {31'd0, overrun}, 32'd0);

    @(negedge clk);
    count = 4'd5;
    waitFall(n);
    checkOutput("t2_latency", n, 32'd2);
    captureFrame(b, bc);
    checkOutput("t2_byte", {24'd0, b}, 32'h35);
    checkOutput("t2_busy_cycles", bc, 32'd40);

    doReset(2);
    @(negedge clk);
    count = 4'hB;
    waitFall(n);
    count = 4'hF;
    captureFrame(b, bc);
    checkOutput("t3_byte_B", {24'd0, b}, 32'h42);
    waitFall(n);
    checkOutput("t3_idle_gap", n, 32'd1);
    captureFrame(b, bc);
    checkOutput("t3_byte_F", {24'd0, b}, 32'h46);

    doReset(2);
    @(negedge clk);
    count   = 4'd1;
    freeRun = 1'b1;
    waitFall(n);
    captureFrame(b, bc);
    checkOutput("t4_byte_1", {24'd0, b}, 32'h31);
    checkOutput("t4_overrun_set", {31'd0, overrun}, 32'd1);
    waitFall(n);
    checkOutput("t4_idle_gap", n, 32'd1);
    tx_en   = 1'b0;
    freeRun = 1'b0;
    captureFrame(b, bc);
    repeat (5) @(negedge clk);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    checkOutput("t4_overrun_clr", {31'd0, overrun}, 32'd0);

    doReset(2);
    tx_en = 1'b0;
    @(negedge clk);
    count = 4'd3;
    repeat (5) @(negedge clk);
    count = 4'd7;
    repeat (20) @(negedge clk);
    checkOutput("t5_tx_gated", {31'd0, tx}, 32'd1);
    checkOutput("t5_busy_gated", {31'd0, busy}, 32'd0);
    tx_en = 1'b1;
    waitFall(n);
    checkOutput("t5_enable_latency", n, 32'd1);
    captureFrame(b, bc);
    checkOutput("t5_byte_7", {24'd0, b}, 32'h37);
    checkOutput("t5_overrun", {31'd0, overrun}, 32'd1);
    repeat (20) @(negedge clk);
    checkOutput("t5_single_frame", {31'd0, busy}, 32'd0);

    doReset(2);
    @(negedge clk);
    count = 4'd9;
    waitFall(n);
    repeat (CPB * 5 + 1) @(negedge clk);
    rst_n = 1'b0;
    count = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("t6_tx_abort", {31'd0, tx}, 32'd1);
    checkOutput("t6_busy_abort", {31'd0, busy}, 32'd0);
    repeat (30) @(negedge clk);
    checkOutput("t6_no_resume", {31'd0, busy}, 32'd0);
    @(negedge clk);
    count = 4'd2;
    waitFall(n);
    captureFrame(b, bc);
    checkOutput("t6_byte_2", {24'd0, b}, 32'h32);

    applyStimulus(3000);
    repeat (2 * FRAME_LEN) @(negedge clk);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
